// File: rtl/vga_pkg.sv
// Shared types and default VGA 640x480@60 timing for the pixel timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    H_ACT   = 2'd0,
    H_FRONT = 2'd1,
    H_SYNC  = 2'd2,
    H_BACK  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYNC  = 2'd2,
    V_BACK  = 2'd3
  } v_state_t;

  localparam int POS_W        = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/sync_axis_fsm.sv
// One timing axis: active/front/sync/back sequencer with an absolute position counter.
// The same sequencing serves both axes; the vertical instance shares the h_state_t encoding.
module sync_axis_fsm
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             adv,
  output logic [POS_W-1:0] pos_o,
  output logic             sync_n_o,
  output logic             active_o,
  output logic             wrap_o
);

  h_state_t           state_q, state_d;
  logic [POS_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               sync_n_q, sync_n_d;
  logic               active_q, active_d;
  logic [POS_W-1:0]   len_m1;
  logic               last;

  always_comb begin
    len_m1 = POS_W'(ACTIVE - 1);
    case (state_q)
      H_ACT:   len_m1 = POS_W'(ACTIVE - 1);
      H_FRONT: len_m1 = POS_W'(FP - 1);
      H_SYNC:  len_m1 = POS_W'(SYNC - 1);
      H_BACK:  len_m1 = POS_W'(BP - 1);
      default: len_m1 = POS_W'(ACTIVE - 1);
    endcase
  end

  assign last   = (cnt_q == len_m1);
  // Leaving the back porch is the end of the axis period.
  assign wrap_o = adv & last & (state_q == H_BACK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    if (adv) begin
      pos_d = wrap_o ? '0 : pos_q + POS_W'(1);
      if (last) begin
        cnt_d = '0;
        case (state_q)
          H_ACT:   state_d = H_FRONT;
          H_FRONT: state_d = H_SYNC;
          H_SYNC:  state_d = H_BACK;
          H_BACK:  state_d = H_ACT;
          default: state_d = H_ACT;
        endcase
      end else begin
        cnt_d = cnt_q + POS_W'(1);
      end
    end
    sync_n_d = (state_d != H_SYNC);
    active_d = (state_d == H_ACT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= H_ACT;
      cnt_q    <= '0;
      pos_q    <= '0;
      sync_n_q <= 1'b1;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign pos_o    = pos_q;
  assign sync_n_o = sync_n_q;
  assign active_o = active_q;

endmodule

// File: rtl/pixel_timing_gen.sv
// VGA-style raster timing: edge-detects the divided pixel flag and steps
// horizontal and vertical sequencers, producing syncs, blanking and position.
module pixel_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       flag_pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  logic flag_prev_q;
  logic tick;
  logic h_wrap, v_wrap;
  logic h_active, v_active;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // flag_prev tracks the flag even while disabled, so edges seen then are consumed.
  assign tick = enable & flag_pixel & ~flag_prev_q;

  sync_axis_fsm #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .n_rst    (n_rst),
    .adv      (tick),
    .pos_o    (pixel_x),
    .sync_n_o (hsync),
    .active_o (h_active),
    .wrap_o   (h_wrap)
  );

  sync_axis_fsm #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .n_rst    (n_rst),
    .adv      (h_wrap),
    .pos_o    (pixel_y),
    .sync_n_o (vsync),
    .active_o (v_active),
    .wrap_o   (v_wrap)
  );

  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      flag_prev_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      flag_prev_q   <= flag_pixel;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign video_on    = h_active & v_active;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench for pixel_timing_gen on a reduced raster (25 x 15) so full frames stay short.
module tb_pixel_timing_gen;

  localparam int TH_ACT = 16, TH_FP = 2, TH_SY = 4, TH_BP = 3;
  localparam int TV_ACT = 8,  TV_FP = 2, TV_SY = 2, TV_BP = 3;
  localparam int PERIOD = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable;
  logic       flag_pixel;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int last_ls = -1, last_fs = -1;
  int ls_period = 0, fs_period = 0, fs_count = 0;

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } vec_t;

  vec_t tbl[15];

  pixel_timing_gen #(
    .H_ACTIVE (TH_ACT), .H_FP (TH_FP), .H_SYNC (TH_SY), .H_BP (TH_BP),
    .V_ACTIVE (TV_ACT), .V_FP (TV_FP), .V_SYNC (TV_SY), .V_BP (TV_BP)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .flag_pixel  (flag_pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (line_start === 1'b1) begin
      if (last_ls >= 0) ls_period = cyc - last_ls;
      last_ls = cyc;
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
      fs_count++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk) flag_pixel = 1'b1;
    @(negedge clk) flag_pixel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_period();
    tick();
    idle(PERIOD - 2);
  endtask

  task automatic chk_pos(input string name, input int x, input int y);
    chk({name, ".x"}, 32'(pixel_x), 32'(x));
    chk({name, ".y"}, 32'(pixel_y), 32'(y));
  endtask

  initial begin
    int cur_t;
    logic [9:0] fx, fy;

    // t, x, y, hsync, vsync, video_on on the 25x15 raster
    tbl[0]  = '{1,   10'd1,  10'd0,  1'b1, 1'b1, 1'b1};
    tbl[1]  = '{15,  10'd15, 10'd0,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{16,  10'd16, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{17,  10'd17, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{18,  10'd18, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{21,  10'd21, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{22,  10'd22, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{24,  10'd24, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{25,  10'd0,  10'd1,  1'b1, 1'b1, 1'b1};
    tbl[9]  = '{200, 10'd0,  10'd8,  1'b1, 1'b1, 1'b0};
    tbl[10] = '{249, 10'd24, 10'd9,  1'b1, 1'b1, 1'b0};
    tbl[11] = '{250, 10'd0,  10'd10, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{268, 10'd18, 10'd10, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{300, 10'd0,  10'd12, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{374, 10'd24, 10'd14, 1'b1, 1'b1, 1'b0};

    n_rst = 1'b0;
    enable = 1'b1;
    flag_pixel = 1'b0;
    idle(3);
    chk_pos("reset", 0, 0);
    chk("reset.hsync", 32'(hsync), 1);
    chk("reset.vsync", 32'(vsync), 1);
    chk("reset.video_on", 32'(video_on), 1);
    chk("reset.line_start", 32'(line_start), 0);
    chk("reset.frame_start", 32'(frame_start), 0);
    n_rst = 1'b1;
    idle(2);

    cur_t = 0;
    for (int i = 0; i < 15; i++) begin
      while (cur_t < tbl[i].t) begin
        tick_period();
        cur_t++;
      end
      chk($sformatf("vec%0d.x", i), 32'(pixel_x), 32'(tbl[i].x));
      chk($sformatf("vec%0d.y", i), 32'(pixel_y), 32'(tbl[i].y));
      chk($sformatf("vec%0d.hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d.vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d.video_on", i), 32'(video_on), 32'(tbl[i].von));
    end

    // last pixel of the frame -> both axes wrap on one edge
    tick();
    chk_pos("wrap", 0, 0);
    chk("wrap.line_start", 32'(line_start), 1);
    chk("wrap.frame_start", 32'(frame_start), 1);
    chk("wrap.video_on", 32'(video_on), 1);
    @(negedge clk);
    chk("wrap.line_start_drop", 32'(line_start), 0);
    chk("wrap.frame_start_drop", 32'(frame_start), 0);
    idle(PERIOD - 3);

    repeat (375) tick_period();
    chk_pos("frame2", 0, 0);
    chk("line_period", 32'(ls_period), 32'(25 * PERIOD));
    chk("frame_period", 32'(fs_period), 32'(375 * PERIOD));
    chk("frame_count", 32'(fs_count), 2);

    // freeze while disabled, flag still toggling
    repeat (3) tick_period();
    chk_pos("pre_freeze", 3, 0);
    fx = pixel_x;
    fy = pixel_y;
    @(negedge clk) enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) flag_pixel = ~flag_pixel;
      chk("freeze.x", 32'(pixel_x), 32'(3));
      chk("freeze.y", 32'(pixel_y), 32'(0));
      chk("freeze.flags", {27'd0, hsync, vsync, video_on, line_start, frame_start}, 32'b11100);
    end
    @(negedge clk) begin
      flag_pixel = 1'b0;
      enable = 1'b1;
    end
    chk("freeze.hold_x", 32'(pixel_x), 32'(fx));
    chk("freeze.hold_y", 32'(pixel_y), 32'(fy));
    idle(1);
    tick_period();
    chk_pos("resume", 4, 0);

    // held-high flag gives a single tick
    @(negedge clk) flag_pixel = 1'b1;
    idle(20);
    flag_pixel = 1'b0;
    chk_pos("held_flag", 5, 0);
    idle(2);

    // asynchronous reset mid-line, then tick on the first clock after release
    repeat (4) tick_period();
    chk_pos("pre_reset", 9, 0);
    @(negedge clk) n_rst = 1'b0;
    #1;
    chk_pos("async_reset", 0, 0);
    chk("async_reset.video_on", 32'(video_on), 1);
    chk("async_reset.hsync", 32'(hsync), 1);
    @(negedge clk) begin
      flag_pixel = 1'b1;
      n_rst = 1'b1;
    end
    @(negedge clk) flag_pixel = 1'b0;
    chk_pos("post_reset", 1, 0);
    chk("post_reset.line_start", 32'(line_start), 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
